// File: rtl/lfsr_pkg.sv
// Shared types, defaults and the Galois step function for the LFSR arbiter.
package lfsr_pkg;

    // Widest LFSR the step helper supports; callers zero-extend into it.
    localparam int unsigned LFSR_MAX_W = 32;

    localparam logic [7:0] DEF_TAPS      = 8'hB8;
    localparam logic [7:0] DEF_SEED_INIT = 8'h01;

    typedef enum logic {
        WARM  = 1'b0,
        SERVE = 1'b1
    } lfsr_arb_state_t;

    // Galois right-shift step; upper unused bits of s and taps must be zero.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Seedable Galois LFSR register.
//   clk, rst_n : clock, async active-low reset (state -> SEED_INIT)
//   load       : load load_val this cycle (priority over step)
//   load_val   : value to load
//   step       : advance one Galois step
//   state      : current LFSR value
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      TAPS      = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0]      SEED_INIT = WIDTH'(DEF_SEED_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] stepped;

    assign stepped = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));

    // Load wins over step; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter handing out words of a shared, reseedable Galois LFSR.
//   clk, rst_n  : clock, async active-low reset
//   req         : per-requester request, held until granted
//   gnt         : combinational one-hot/zero grant; transfer on req & gnt
//   rnd_data    : current LFSR word, valid for the granted requester
//   seed_valid  : reseed request
//   seed_data   : new seed (zero replaced by SEED_INIT)
//   seed_ready  : high in SERVE
//   warming     : high in WARM (post-reset / post-reseed discard period)
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned      NUM_REQ   = 4,
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(DEF_SEED_INIT),
    parameter int unsigned      WARMUP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rnd_data,
    input  logic               seed_valid,
    input  logic [WIDTH-1:0]   seed_data,
    output logic               seed_ready,
    output logic               warming
);

    localparam int unsigned CNT_W = ($clog2(WARMUP + 1) < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int unsigned PTR_W = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);
    localparam lfsr_arb_state_t RST_STATE = (WARMUP > 0) ? WARM : SERVE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

    lfsr_arb_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_load_val;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_state;

    logic               serving;
    logic               seed_hs;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     idx;
    logic [NUM_REQ-1:0] gnt_int;

    assign serving = (state_q == SERVE);
    assign seed_hs = serving & seed_valid;

    // Search from the pointer, wrapping explicitly for non-power-of-2 counts.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(NUM_REQ)) begin
                idx = idx - (PTR_W + 1)'(NUM_REQ);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    // A seed handshake blocks any grant in the same cycle.
    always_comb begin
        gnt_int = '0;
        if (serving && !seed_hs && found) begin
            gnt_int[win] = 1'b1;
        end
    end

    // Next-state, counter, pointer and LFSR control.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        lfsr_load     = 1'b0;
        lfsr_load_val = lfsr_state;
        lfsr_step     = 1'b0;
        case (state_q)
            WARM: begin
                lfsr_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (seed_hs) begin
                    lfsr_load     = 1'b1;
                    lfsr_load_val = (seed_data == '0) ? SEED_INIT : seed_data;
                    cnt_d         = '0;
                    state_d       = (WARMUP > 0) ? WARM : SERVE;
                end else if (found) begin
                    lfsr_step = 1'b1;
                    ptr_d     = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    lfsr_core #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .SEED_INIT (SEED_INIT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    // Handshake outputs are held low while reset is asserted, even when
    // the reset state is SERVE.
    assign gnt        = gnt_int & {NUM_REQ{rst_n}};
    assign seed_ready = serving & rst_n;
    assign warming    = ~serving;
    assign rnd_data   = lfsr_state;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed, table-driven bench for lfsr_arbiter (WARMUP=4 and WARMUP=0 instances).
module tb_lfsr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rnd_data;
    logic       seed_valid;
    logic [7:0] seed_data;
    logic       seed_ready;
    logic       warming;

    logic [3:0] req0;
    logic [3:0] gnt0;
    logic [7:0] rnd0;
    logic       sv0;
    logic [7:0] sd0;
    logic       sr0;
    logic       warm0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .warming    (warming)
    );

    lfsr_arbiter #(.WARMUP(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req0),
        .gnt        (gnt0),
        .rnd_data   (rnd0),
        .seed_valid (sv0),
        .seed_data  (sd0),
        .seed_ready (sr0),
        .warming    (warm0)
    );

    typedef struct {
        logic [3:0] req;
        logic       sv;
        logic [7:0] sd;
        logic [3:0] gnt;
        logic [7:0] rnd;
        logic       warm;
        logic       sr;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent model of the Galois step.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        logic [7:0] r;
        r = {1'b0, s[7:1]};
        if (s[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] s_start;
        int         p;

        // Per-cycle vectors from reset release: warm-up, round robin,
        // single requester, idle hold, reseed with zero, WARM ignores seed.
        vecs[0]  = '{4'hF, 1'b0, 8'h00, 4'h0, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{4'hF, 1'b0, 8'h00, 4'h0, 8'hB8, 1'b1, 1'b0};
        vecs[2]  = '{4'hF, 1'b0, 8'h00, 4'h0, 8'h5C, 1'b1, 1'b0};
        vecs[3]  = '{4'hF, 1'b0, 8'h00, 4'h0, 8'h2E, 1'b1, 1'b0};
        vecs[4]  = '{4'hF, 1'b0, 8'h00, 4'h1, 8'h17, 1'b0, 1'b1};
        vecs[5]  = '{4'hF, 1'b0, 8'h00, 4'h2, 8'hB3, 1'b0, 1'b1};
        vecs[6]  = '{4'hF, 1'b0, 8'h00, 4'h4, 8'hE1, 1'b0, 1'b1};
        vecs[7]  = '{4'hF, 1'b0, 8'h00, 4'h8, 8'hC8, 1'b0, 1'b1};
        vecs[8]  = '{4'hF, 1'b0, 8'h00, 4'h1, 8'h64, 1'b0, 1'b1};
        vecs[9]  = '{4'h4, 1'b0, 8'h00, 4'h4, 8'h32, 1'b0, 1'b1};
        vecs[10] = '{4'h4, 1'b0, 8'h00, 4'h4, 8'h19, 1'b0, 1'b1};
        vecs[11] = '{4'h4, 1'b0, 8'h00, 4'h4, 8'hB4, 1'b0, 1'b1};
        vecs[12] = '{4'h0, 1'b0, 8'h00, 4'h0, 8'h5A, 1'b0, 1'b1};
        vecs[13] = '{4'h0, 1'b0, 8'h00, 4'h0, 8'h5A, 1'b0, 1'b1};
        vecs[14] = '{4'h2, 1'b0, 8'h00, 4'h2, 8'h5A, 1'b0, 1'b1};
        vecs[15] = '{4'h9, 1'b0, 8'h00, 4'h8, 8'h2D, 1'b0, 1'b1};
        vecs[16] = '{4'h9, 1'b0, 8'h00, 4'h1, 8'hAE, 1'b0, 1'b1};
        vecs[17] = '{4'hF, 1'b1, 8'h00, 4'h0, 8'h57, 1'b0, 1'b1};
        vecs[18] = '{4'hF, 1'b1, 8'h55, 4'h0, 8'h01, 1'b1, 1'b0};
        vecs[19] = '{4'hF, 1'b0, 8'h00, 4'h0, 8'hB8, 1'b1, 1'b0};
        vecs[20] = '{4'hF, 1'b0, 8'h00, 4'h0, 8'h5C, 1'b1, 1'b0};
        vecs[21] = '{4'hF, 1'b0, 8'h00, 4'h0, 8'h2E, 1'b1, 1'b0};
        vecs[22] = '{4'hF, 1'b0, 8'h00, 4'h2, 8'h17, 1'b0, 1'b1};
        vecs[23] = '{4'hF, 1'b0, 8'h00, 4'h4, 8'hB3, 1'b0, 1'b1};

        rst_n      = 1'b0;
        req        = 4'hF;
        seed_valid = 1'b0;
        seed_data  = 8'h00;
        req0       = 4'h0;
        sv0        = 1'b0;
        sd0        = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_seed_ready", 32'(seed_ready), 32'h0);
        chk("rst_warming", 32'(warming), 32'h1);
        chk("rst_rnd", 32'(rnd_data), 32'h01);
        chk("rst_w0_seed_ready", 32'(sr0), 32'h0);
        chk("rst_w0_warming", 32'(warm0), 32'h0);
        chk("rst_w0_gnt", 32'(gnt0), 32'h0);

        next_cycle();
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            req        = vecs[k].req;
            seed_valid = vecs[k].sv;
            seed_data  = vecs[k].sd;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(vecs[k].gnt));
            chk($sformatf("v%0d_rnd", k), 32'(rnd_data), 32'(vecs[k].rnd));
            chk($sformatf("v%0d_warming", k), 32'(warming), 32'(vecs[k].warm));
            chk($sformatf("v%0d_seed_ready", k), 32'(seed_ready), 32'(vecs[k].sr));
            next_cycle();
        end
        seed_valid = 1'b0;

        // Full period with all requesters active: pointer at 3, state E1.
        req     = 4'hF;
        s       = 8'hE1;
        s_start = s;
        p       = 3;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            chk($sformatf("per%0d_gnt", k), 32'(gnt), 32'(4'b0001 << p));
            chk($sformatf("per%0d_rnd", k), 32'(rnd_data), 32'(s));
            s = model_step(s);
            p = (p + 1) % 4;
            next_cycle();
        end
        @(negedge clk);
        chk("period_repeat", 32'(rnd_data), 32'(s_start));
        next_cycle();

        // WARMUP=0 instance: reseed with B8 alongside pending requests.
        req0 = 4'hF;
        sv0  = 1'b1;
        sd0  = 8'hB8;
        @(negedge clk);
        chk("w0_seed_gnt", 32'(gnt0), 32'h0);
        chk("w0_seed_ready", 32'(sr0), 32'h1);
        chk("w0_seed_warming", 32'(warm0), 32'h0);
        next_cycle();
        sv0  = 1'b0;
        req0 = 4'h1;
        @(negedge clk);
        chk("w0_g1_gnt", 32'(gnt0), 32'h1);
        chk("w0_g1_rnd", 32'(rnd0), 32'hB8);
        chk("w0_g1_warming", 32'(warm0), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("w0_g2_gnt", 32'(gnt0), 32'h1);
        chk("w0_g2_rnd", 32'(rnd0), 32'h5C);
        chk("w0_g2_warming", 32'(warm0), 32'h0);
        next_cycle();
        req0 = 4'h0;

        // Asynchronous reset mid-stream while grants are flowing.
        req = 4'hF;
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_seed_ready", 32'(seed_ready), 32'h0);
        chk("mid_rst_warming", 32'(warming), 32'h1);
        chk("mid_rst_rnd", 32'(rnd_data), 32'h01);
        chk("mid_rst_w0_rnd", 32'(rnd0), 32'h01);
        chk("mid_rst_w0_seed_ready", 32'(sr0), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid_warm%0d_warming", k), 32'(warming), 32'h1);
            chk($sformatf("mid_warm%0d_gnt", k), 32'(gnt), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("mid_restart_gnt", 32'(gnt), 32'h1);
        chk("mid_restart_rnd", 32'(rnd_data), 32'h17);
        next_cycle();
        @(negedge clk);
        chk("mid_restart2_gnt", 32'(gnt), 32'h2);
        chk("mid_restart2_rnd", 32'(rnd_data), 32'hB3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
